// File: rtl/xalu_ise_seq.sv
// xalu_ise_seq: iterative Jambu funnel-shift ISE ALU (FSRI / FSR_k), STEP bits per cycle.
// Optional busy-cycle counter port ise_busy_cnt enabled by defining XALU_ISE_PERF_EN.
module xalu_ise_seq #(
  parameter int         XLEN  = 32,
  parameter logic [2:0] ISE_V = 3'b110,
  parameter int         STEP  = 4
) (
  input  logic            ise_clk,
  input  logic            ise_rst,
  input  logic [4:0]      ise_fn,
  input  logic [6:0]      ise_imm,
  input  logic [XLEN-1:0] ise_in1,
  input  logic [XLEN-1:0] ise_in2,
  input  logic            ise_val,
  output logic            ise_rdy,
  output logic            ise_sel,
  output logic            ise_oval,
  input  logic            ise_ordy,
`ifdef XALU_ISE_PERF_EN
  output logic [XLEN-1:0] ise_out,
  output logic [31:0]     ise_busy_cnt
`else
  output logic [XLEN-1:0] ise_out
`endif
);
  localparam int SW = $clog2(XLEN);
  localparam int LS = $clog2(STEP);
  localparam logic [SW-1:0] SMASK = SW'(STEP - 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [2*XLEN-1:0] win;
  logic [SW-1:0] cnt, shamt, steps;
  logic fsri, fsrk, acc, unused_fn;
  assign fsri = ISE_V[1] && ise_fn[1:0] == 2'b01 && ise_imm[6:SW] == '0;
  assign fsrk = ISE_V[2] && ise_fn[1:0] == 2'b11 && ise_imm < 7'd4;
  assign shamt = fsri ? ise_imm[SW-1:0] :
                 ise_imm == 7'd3 ? SW'(27) :
                 ise_imm == 7'd2 ? SW'(21) :
                 ise_imm == 7'd1 ? SW'(6) : SW'(15);
  assign steps = shamt >> LS;
  assign ise_sel = fsri | fsrk;
  assign ise_rdy = state == IDLE || (state == DONE && ise_ordy);
  assign acc = ise_val & ise_sel & ise_rdy;
  assign ise_oval = state == DONE;
  assign ise_out = ise_oval ? win[XLEN-1:0] : '0;
  assign unused_fn = ^{ise_fn[4:2], ISE_V[0]};
  // Load pre-aligned window on accept, then walk it down STEP bits per cycle
  always_ff @(posedge ise_clk or posedge ise_rst)
    if (ise_rst) begin
      state <= IDLE;
      win <= '0;
      cnt <= '0;
    end else if (acc) begin
      win <= {ise_in2, ise_in1} >> (shamt & SMASK);
      cnt <= steps;
      state <= steps != '0 ? SHIFT : DONE;
    end else if (state == SHIFT) begin
      win <= win >> STEP;
      cnt <= cnt - 1'b1;
      state <= cnt == SW'(1) ? DONE : SHIFT;
    end else if (state == DONE && ise_ordy)
      state <= IDLE;
`ifdef XALU_ISE_PERF_EN
  // Count every cycle spent outside IDLE, wrapping naturally
  always_ff @(posedge ise_clk or posedge ise_rst)
    if (ise_rst) ise_busy_cnt <= '0;
    else if (state != IDLE) ise_busy_cnt <= ise_busy_cnt + 32'd1;
`endif
endmodule
